data_mem_responder: RTL and testbench

- Memory-side responder for the control path's data load/store interface.
- Accepts level-held `ld`/`st` requests, enforces a segment window, and models a configurable access latency.
- Drives `wait_data` and `data_segv` back to the control path; returns load data on `rdata`.
- Sits between the control path/datapath and a word-addressed data RAM, opposite the FSM's WAIT_LOAD/WAIT_STORE states.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/data_ram.sv | 24 ++
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 tb/tb_data_mem_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data memory responder.
// States, word width and fault-reason helper.
package mem_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP,
      HOLD
   } state_e;

   typedef enum logic [1:0] {
      FR_NONE,
      FR_BOUNDS,
      FR_DOUBLE
   } fault_e;

   // A double request outranks a bounds violation.
   function automatic fault_e fault_reason(
      input logic ld,
      input logic st,
      input logic oob
   );
      if (ld & st) return FR_DOUBLE;
      if (oob) return FR_BOUNDS;
      return FR_NONE;
   endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port word RAM, synchronous write.
// Read data is registered.
module data_ram
   import mem_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the control path's load/store port.
// Segment check, configurable latency, one-cycle response.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld,
   input  logic              st,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] seg_base,
   input  logic [ADDR_W-1:0] seg_limit,
   output logic [31:0]       rdata,
   output logic              wait_data,
   output logic              data_segv
);

   localparam bit DIRECT = (LATENCY == 1);
   localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

   state_e            state;
   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic              ld_q;
   logic              st_q;
   logic              fault_q;
   logic [WORD_W-1:0] rdata_q;

   logic              req;
   logic              oob;
   logic              fault;
   logic              good_ld;

   logic              ram_we;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_addr;
   logic [WORD_W-1:0] ram_wdata;
   logic [WORD_W-1:0] ram_q;

   assign req = ld | st;

   assign oob = (32'(addr) >= 32'(DEPTH))
              | (addr < seg_base)
              | (addr >= seg_limit);

   assign fault = (fault_reason(ld, st, oob) != FR_NONE);

   assign wait_data = req & ((state == IDLE) | (state == BUSY));

   assign good_ld = ld_q & ~fault_q;

   assign rdata = ((state == RESP) && good_ld) ? ram_q : rdata_q;

   // The RAM is driven one cycle ahead of RESP; with unit latency
   // that cycle is the acceptance cycle itself.
   always_comb begin
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      if (!reset) begin
         if (DIRECT) begin
            if (state == IDLE && req && !fault) begin
               ram_addr  = addr;
               ram_wdata = wdata;
               ram_we    = st;
               ram_re    = ld;
            end
         end else if (state == BUSY && req && cnt == CW'(1)) begin
            ram_we = st_q;
            ram_re = ld_q;
         end
      end
   end

   data_ram #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_q)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         ld_q      <= 1'b0;
         st_q      <= 1'b0;
         fault_q   <= 1'b0;
         rdata_q   <= '0;
         data_segv <= 1'b0;
      end else begin
         data_segv <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req) begin
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  ld_q    <= ld;
                  st_q    <= st;
                  fault_q <= fault;
                  if (fault) begin
                     state     <= RESP;
                     data_segv <= 1'b1;
                  end else if (DIRECT) begin
                     state <= RESP;
                     cnt   <= '0;
                  end else begin
                     state <= BUSY;
                     cnt   <= CW'(LATENCY - 1);
                  end
               end
            end
            BUSY: begin
               if (!req) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == CW'(1)) begin
                  state <= RESP;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESP: begin
               if (good_ld) rdata_q <= ram_q;
               state <= req ? HOLD : IDLE;
            end
            HOLD: begin
               if (!req) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at latencies 1, 2 and 3.
// Shared address/data/segment/reset; per-instance requests.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [7:0]  seg_base;
   logic [7:0]  seg_limit;

   logic        ld1, st1, wt1, sv1;
   logic        ld2, st2, wt2, sv2;
   logic        ld3, st3, wt3, sv3;
   logic [31:0] rd1, rd2, rd3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.LATENCY(1)) u1 (
      .clk(clk), .reset(reset), .ld(ld1), .st(st1), .addr(addr),
      .wdata(wdata), .seg_base(seg_base), .seg_limit(seg_limit),
      .rdata(rd1), .wait_data(wt1), .data_segv(sv1)
   );

   data_mem_responder #(.LATENCY(2)) u2 (
      .clk(clk), .reset(reset), .ld(ld2), .st(st2), .addr(addr),
      .wdata(wdata), .seg_base(seg_base), .seg_limit(seg_limit),
      .rdata(rd2), .wait_data(wt2), .data_segv(sv2)
   );

   data_mem_responder #(.LATENCY(3)) u3 (
      .clk(clk), .reset(reset), .ld(ld3), .st(st3), .addr(addr),
      .wdata(wdata), .seg_base(seg_base), .seg_limit(seg_limit),
      .rdata(rd3), .wait_data(wt3), .data_segv(sv3)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset = 1'b1;
      {ld1, st1, ld2, st2, ld3, st3} = '0;
      addr = '0; wdata = '0; seg_base = 8'd0; seg_limit = 8'd16;
      cyc(); cyc();
      chk("rst_wait2", {31'b0, wt2}, 32'h0);
      chk("rst_segv2", {31'b0, sv2}, 32'h0);
      chk("rst_rdata2", rd2, 32'h0);
      reset = 1'b0;
      cyc();

      // store 5 <= DEADBEEF at latency 2
      st2 = 1; addr = 8'd5; wdata = 32'hDEADBEEF; settle();
      chk("st5_wait_t0", {31'b0, wt2}, 32'h1);
      cyc();
      chk("st5_wait_t1", {31'b0, wt2}, 32'h1);
      chk("st5_segv_t1", {31'b0, sv2}, 32'h0);
      cyc();
      chk("st5_wait_resp", {31'b0, wt2}, 32'h0);
      chk("st5_segv_resp", {31'b0, sv2}, 32'h0);
      st2 = 0; cyc();

      // load 5
      ld2 = 1; settle();
      chk("ld5_wait_t0", {31'b0, wt2}, 32'h1);
      cyc();
      chk("ld5_wait_t1", {31'b0, wt2}, 32'h1);
      cyc();
      chk("ld5_wait_resp", {31'b0, wt2}, 32'h0);
      chk("ld5_rdata", rd2, 32'hDEADBEEF);
      chk("ld5_segv", {31'b0, sv2}, 32'h0);
      ld2 = 0; cyc();
      chk("ld5_rdata_hold", rd2, 32'hDEADBEEF);

      // preload 3 and 7
      st2 = 1; addr = 8'd3; wdata = 32'hA5A5A5A5; cyc(); cyc();
      st2 = 0; cyc();
      st2 = 1; addr = 8'd7; wdata = 32'h00000077; cyc(); cyc();
      st2 = 0; cyc();

      // bounds faults
      seg_base = 8'd4; seg_limit = 8'd8;
      ld2 = 1; addr = 8'd8; settle();
      chk("ld8_wait", {31'b0, wt2}, 32'h1);
      cyc();
      chk("ld8_segv", {31'b0, sv2}, 32'h1);
      chk("ld8_wait_resp", {31'b0, wt2}, 32'h0);
      ld2 = 0; cyc();
      chk("ld8_segv_drop", {31'b0, sv2}, 32'h0);
      st2 = 1; addr = 8'd3; wdata = 32'h11111111; settle();
      chk("st3_wait", {31'b0, wt2}, 32'h1);
      cyc();
      chk("st3_segv", {31'b0, sv2}, 32'h1);
      st2 = 0; cyc();
      chk("st3_segv_drop", {31'b0, sv2}, 32'h0);
      seg_base = 8'd0;
      ld2 = 1; addr = 8'd3; cyc(); cyc();
      chk("ld3_old", rd2, 32'hA5A5A5A5);
      ld2 = 0; cyc();

      // edge-legal and double request
      seg_base = 8'd4; seg_limit = 8'd8;
      ld2 = 1; addr = 8'd7; cyc();
      chk("ld7_wait_t1", {31'b0, wt2}, 32'h1);
      cyc();
      chk("ld7_segv", {31'b0, sv2}, 32'h0);
      chk("ld7_rdata", rd2, 32'h00000077);
      ld2 = 0; cyc();
      ld2 = 1; st2 = 1; addr = 8'd6; cyc();
      chk("dbl_segv", {31'b0, sv2}, 32'h1);
      ld2 = 0; st2 = 0; cyc();

      // held request goes to HOLD
      seg_base = 8'd0; seg_limit = 8'd16;
      ld2 = 1; addr = 8'd5; cyc(); cyc();
      chk("hold_rdata", rd2, 32'hDEADBEEF);
      cyc();
      chk("hold_wait1", {31'b0, wt2}, 32'h0);
      cyc();
      chk("hold_wait2", {31'b0, wt2}, 32'h0);
      cyc();
      chk("hold_wait3", {31'b0, wt2}, 32'h0);
      chk("hold_segv", {31'b0, sv2}, 32'h0);
      ld2 = 0; cyc();
      ld2 = 1; addr = 8'd7; settle();
      chk("hold_idle_again", {31'b0, wt2}, 32'h1);
      cyc(); cyc();
      chk("hold_next_rdata", rd2, 32'h00000077);
      ld2 = 0; cyc();

      // latency 3: preload, then aborts
      st3 = 1; addr = 8'd2; wdata = 32'h0BAD0002; cyc(); cyc();
      chk("l3_st_wait_t2", {31'b0, wt3}, 32'h1);
      cyc();
      chk("l3_st_wait_resp", {31'b0, wt3}, 32'h0);
      st3 = 0; cyc();
      st3 = 1; wdata = 32'h00001234; cyc();
      st3 = 0; settle();
      chk("abort_wait", {31'b0, wt3}, 32'h0);
      cyc();
      ld3 = 1; cyc(); cyc(); cyc();
      chk("abort_rdata", rd3, 32'h0BAD0002);
      ld3 = 0; cyc();
      st3 = 1; wdata = 32'h00001234; cyc(); cyc();
      reset = 1'b1; cyc();
      chk("rst_mid_segv", {31'b0, sv3}, 32'h0);
      chk("rst_mid_rdata", rd3, 32'h0);
      reset = 1'b0; st3 = 0; cyc();
      ld3 = 1; settle();
      chk("rst_mid_idle", {31'b0, wt3}, 32'h1);
      cyc(); cyc(); cyc();
      chk("rst_mid_ram", rd3, 32'h0BAD0002);
      ld3 = 0; cyc();

      // latency 1 back-to-back
      st1 = 1; addr = 8'd1; wdata = 32'hCAFEF00D; settle();
      chk("l1_st_wait", {31'b0, wt1}, 32'h1);
      cyc();
      chk("l1_st_resp", {31'b0, wt1}, 32'h0);
      chk("l1_st_segv", {31'b0, sv1}, 32'h0);
      st1 = 0; cyc();
      ld1 = 1; settle();
      chk("l1_ld_wait", {31'b0, wt1}, 32'h1);
      cyc();
      chk("l1_ld_resp", {31'b0, wt1}, 32'h0);
      chk("l1_ld_rdata", rd1, 32'hCAFEF00D);
      ld1 = 0; cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
